// File: rtl/miriscv_imem_responder.sv
// Instruction-memory responder: word RAM with fixed pipelined read latency,
// a byte-enabled boot load port and an optional post-reset NOP clear.
module miriscv_imem_responder #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     DEPTH_WORDS    = 1024,
    parameter int unsigned     READ_LATENCY   = 1,
    parameter logic [XLEN-1:0] BASE_ADDR      = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    output logic              instr_err_o,
    input  logic              load_we_i,
    input  logic [XLEN-1:0]   load_addr_i,
    input  logic [XLEN-1:0]   load_wdata_i,
    input  logic [XLEN/8-1:0] load_be_i,
    output logic              ready_o
);

    localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned     NBYTES   = XLEN / 8;
    localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
    localparam logic [XLEN-2:0] DEPTH_W  = (XLEN-1)'(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_n;
    logic             init_we;
    logic             run;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Word offset from BASE_ADDR; an address below the base borrows into the
    // top bits and therefore always compares as out of range (no wrap-around).
    function automatic logic [XLEN-2:0] word_off(input logic [XLEN-1:0] addr);
        return {1'b0, addr[XLEN-1:2]} - {1'b0, BASE_ADDR[XLEN-1:2]};
    endfunction

    logic [XLEN-2:0]  f_off;
    logic             f_ok;
    logic [IDX_W-1:0] f_idx;
    logic [XLEN-2:0]  l_off;
    logic             l_ok;
    logic [IDX_W-1:0] l_idx;

    assign f_off = word_off(instr_addr_i);
    assign f_ok  = (f_off < DEPTH_W) && (instr_addr_i[1:0] == 2'b00);
    assign f_idx = f_off[IDX_W-1:0];

    assign l_off = word_off(load_addr_i);
    assign l_ok  = (l_off < DEPTH_W) && (load_addr_i[1:0] == 2'b00);
    assign l_idx = l_off[IDX_W-1:0];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        init_we = 1'b0;
        unique case (state)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_n   = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
            end
            default: begin
            end
        endcase
    end

    assign run     = (state == ST_RUN);
    assign ready_o = run;

    logic accept;
    logic load_ok;

    assign accept  = instr_req_i && run && !rst_i;
    assign load_ok = load_we_i && l_ok && run && !rst_i;

    // ---------------- array write side ----------------
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            mem[cnt] <= NOP;
        end else if (load_ok) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (load_be_i[b]) begin
                    mem[l_idx][8*b +: 8] <= load_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read latency pipeline ----------------
    logic [READ_LATENCY-1:0] pv;
    logic [READ_LATENCY-1:0] pe;
    logic [XLEN-1:0]         pd [READ_LATENCY];
    logic [XLEN-1:0]         held;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pv <= '0;
        end else begin
            pv[0] <= accept;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    // Stage 0 samples the array with a non-blocking read, so a same-cycle
    // load write to that word is observed by the next fetch, not this one.
    always_ff @(posedge clk_i) begin
        pe[0] <= !f_ok;
        pd[0] <= f_ok ? mem[f_idx] : NOP;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held <= NOP;
        end else if (pv[READ_LATENCY-1]) begin
            held <= pd[READ_LATENCY-1];
        end
    end

    assign instr_rvalid_o = pv[READ_LATENCY-1];
    assign instr_err_o    = pv[READ_LATENCY-1] & pe[READ_LATENCY-1];
    assign instr_rdata_o  = pv[READ_LATENCY-1] ? pd[READ_LATENCY-1] : held;

endmodule

// File: tb/tb_miriscv_imem_responder.sv
// Scoreboard bench for miriscv_imem_responder (DEPTH_WORDS=16, READ_LATENCY=3).
module tb_miriscv_imem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;

    always #5 clk = ~clk;

    miriscv_imem_responder #(
        .XLEN(32),
        .DEPTH_WORDS(16),
        .READ_LATENCY(LAT),
        .BASE_ADDR(32'h0),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .instr_req_i(req),
        .instr_addr_i(addr),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o(rdata),
        .instr_err_o(err),
        .load_we_i(we),
        .load_addr_i(laddr),
        .load_wdata_i(wdata),
        .load_be_i(be),
        .ready_o(ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } exp_t;

    exp_t q[$];

    always @(posedge clk) cyc++;

    // Monitor: every response must match the oldest expectation, on time.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rvalid === 1'b1) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid cyc=%0d got data=%h err=%b, required no response",
                             cyc, rdata, err);
                end else begin
                    e = q.pop_front();
                    if (rdata !== e.data || err !== e.err || cyc != e.at) begin
                        errors++;
                        $display("FAIL response got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                                 rdata, err, cyc, e.data, e.err, e.at);
                    end
                end
            end else if (rvalid !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d got rvalid=%b err=%b, required 0 0", cyc, rvalid, err);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic er);
        req  = 1'b1;
        addr = a;
        q.push_back('{data: d, err: er, at: cyc + LAT});
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        we    = 1'b1;
        laddr = a;
        wdata = d;
        be    = b;
        @(negedge clk);
        we = 1'b0;
        be = 4'h0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d responses outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    // Called at the negedge where rst drops; requests are held high
    // throughout INIT and must all be ignored.
    task automatic wait_ready(input string name);
        int n = 0;
        req  = 1'b1;
        addr = 32'h0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        check(name, 32'(n), 32'd16);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        addr  = '0;
        we    = 1'b0;
        laddr = '0;
        wdata = '0;
        be    = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Reset state
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_rdata",  rdata,       32'h0000_0013);
        check("rst_ready",  32'(ready),  32'd0);

        // 1: INIT clears array to NOP, 16 cycles
        rst = 1'b0;
        wait_ready("init_cycles");
        for (int i = 0; i < 16; i++) issue(32'(i * 4), 32'h0000_0013, 1'b0);
        drain("clear_readback");

        // 2: byte-enabled merges
        write(32'h8, 32'hDEAD_BEEF, 4'b0011);
        write(32'h8, 32'h1234_5678, 4'b1100);
        issue(32'h8, 32'h1234_BEEF, 1'b0);
        drain("byte_enable");

        // 3: back-to-back fetches, then rdata holds
        write(32'h0, 32'hA000_0000, 4'hF);
        write(32'h4, 32'hA000_0001, 4'hF);
        write(32'h8, 32'hA000_0002, 4'hF);
        write(32'hC, 32'hA000_0003, 4'hF);
        issue(32'h0, 32'hA000_0000, 1'b0);
        issue(32'h4, 32'hA000_0001, 1'b0);
        issue(32'h8, 32'hA000_0002, 1'b0);
        issue(32'hC, 32'hA000_0003, 1'b0);
        drain("back_to_back");
        repeat (3) begin
            check("hold_rdata", rdata, 32'hA000_0003);
            @(negedge clk);
        end

        // 4: misaligned / out-of-range fetch and dropped writes
        issue(32'h2,         32'h0000_0013, 1'b1);
        issue(32'h40,        32'h0000_0013, 1'b1);
        issue(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
        drain("bad_fetch");
        write(32'h2,  32'h5555_5555, 4'hF);
        write(32'h40, 32'h6666_6666, 4'hF);
        write(32'h42, 32'h7777_7777, 4'hF);
        issue(32'h0, 32'hA000_0000, 1'b0);
        issue(32'h4, 32'hA000_0001, 1'b0);
        drain("dropped_write");

        // 5: same-cycle fetch and write return old data
        write(32'h10, 32'h0000_000A, 4'hF);
        we    = 1'b1;
        laddr = 32'h10;
        wdata = 32'h0000_000B;
        be    = 4'hF;
        issue(32'h10, 32'h0000_000A, 1'b0);
        we = 1'b0;
        be = 4'h0;
        issue(32'h10, 32'h0000_000B, 1'b0);
        drain("read_before_write");

        // 6: reset with two responses in flight
        write(32'h4, 32'hCAFE_F00D, 4'hF);
        req  = 1'b1;
        addr = 32'h0;
        @(negedge clk);
        addr = 32'h4;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_rdata",  rdata,      32'h0000_0013);
        check("rst2_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        wait_ready("reinit_cycles");
        issue(32'h4,  32'h0000_0013, 1'b0);
        issue(32'h0,  32'h0000_0013, 1'b0);
        issue(32'h10, 32'h0000_0013, 1'b0);
        drain("reinit_clear");
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
